lfsr_timer: RTL

//  Parametrised XNOR-Fibonacci LFSR timer; next generation of the 4-bit LFSR counter.

---
 rtl/lfsr_pkg.sv | 53 +++++
 rtl/lfsr_step.sv | 18 +
 rtl/lfsr_timer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the XNOR-Fibonacci LFSR family (lfsr_step, lfsr_timer).
// default_taps() returns a maximal-length XNOR feedback mask for widths 3..32.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_WIDTH = 32;
  localparam int unsigned LFSR_MIN_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } lfsr_state_e;

  // Bit i set means state[i] feeds the XNOR; tap n in the classic 1-based tables maps to bit n-1.
  function automatic logic [LFSR_MAX_WIDTH-1:0] default_taps(input int unsigned width);
    logic [LFSR_MAX_WIDTH-1:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = '0;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single step of an XNOR-Fibonacci LFSR: shift left, XNOR of tapped bits into bit 0.
// All-ones is the lockup state; every other value stays inside the maximal-length cycle.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_nxt
);

  logic w_feedback;

  assign w_feedback = ~^(i_state & TAPS);
  assign o_nxt      = {i_state[WIDTH-2:0], w_feedback};

endmodule

// File: rtl/lfsr_timer.sv
// LFSR timer: counts from a loaded seed to a loaded terminal value, one-shot or auto-reload.
// Optional LFSR_LOCKUP_RECOVER_EN forces an all-ones state back to zero and raises a sticky err.
module lfsr_timer
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] RESET_SEED = '0
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] count_to,
  input  logic             periodic,
  input  logic             count_en,
  output logic [WIDTH-1:0] state,
  output logic             busy,
  output logic             done,
  output logic             err
);

  lfsr_state_e      r_fsm,   w_fsm_d;
  logic [WIDTH-1:0] r_state, w_state_d;
  logic [WIDTH-1:0] r_seed,  w_seed_d;
  logic [WIDTH-1:0] r_tgt,   w_tgt_d;
  logic             r_per,   w_per_d;
  logic             r_done,  w_done_d;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_adv;
  logic             w_advance;
  logic             w_match;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .i_state (r_state),
    .o_nxt   (w_nxt)
  );

  assign w_advance = (r_fsm == RUN) && count_en && !clear && !load;

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic w_lockup;
  logic r_err, w_err_d;

  assign w_lockup = (r_state == {WIDTH{1'b1}});
  assign w_adv    = w_lockup ? '0 : w_nxt;

  always_comb begin
    w_err_d = r_err;
    if (clear || load) begin
      w_err_d = 1'b0;
    end else if (w_advance && w_lockup) begin
      w_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_n or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_d;
    end
  end

  assign err = r_err;
`else
  assign w_adv = w_nxt;
  assign err   = 1'b0;
`endif

  // Only the advanced value is compared, so seed == count_to needs a full period to match.
  assign w_match = (w_adv == r_tgt);

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_fsm_d   = r_fsm;
    w_state_d = r_state;
    w_seed_d  = r_seed;
    w_tgt_d   = r_tgt;
    w_per_d   = r_per;
    w_done_d  = r_done;

    if (clear) begin
      w_fsm_d   = IDLE;
      w_state_d = RESET_SEED;
      w_done_d  = 1'b0;
    end else if (load) begin
      w_fsm_d   = RUN;
      w_state_d = seed;
      w_seed_d  = seed;
      w_tgt_d   = count_to;
      w_per_d   = periodic;
      w_done_d  = 1'b0;
    end else begin
      case (r_fsm)
        RUN: begin
          w_done_d = 1'b0;
          if (count_en) begin
            w_state_d = w_adv;
            if (w_match) begin
              w_done_d = 1'b1;
              if (r_per) begin
                w_state_d = r_seed;
              end else begin
                w_fsm_d = HALT;
              end
            end
          end
        end
        HALT: begin
          w_fsm_d = HALT;
        end
        default: begin
          w_fsm_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_n or negedge rst) begin
    if (!rst) begin
      r_fsm   <= IDLE;
      r_state <= RESET_SEED;
      r_seed  <= '0;
      r_tgt   <= '0;
      r_per   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_d;
      r_state <= w_state_d;
      r_seed  <= w_seed_d;
      r_tgt   <= w_tgt_d;
      r_per   <= w_per_d;
      r_done  <= w_done_d;
    end
  end

  assign state = r_state;
  assign busy  = (r_fsm == RUN);
  assign done  = r_done;

endmodule
